// File: rtl/integrate_dump_ctrl.sv
// integrate_dump_ctrl
//   Integrate-and-dump decimator sequencer for the AD9226 sample stream.
//   It sums windows of N signed samples taken from an AXI-Stream slave.
//   It emits one sum per window on an AXI-Stream master with full backpressure.
//
// Ports
//   clk, reset      rising-edge clock, synchronous active-high reset
//   enable          1 = run windows, 0 = drop the partial window and idle
//   dec_len         window length N (0 acts as 1), latched at window start
//   s_axis_*        signed sample input (tdata/tvalid/tready)
//   m_axis_*        signed window sum output (tdata/tvalid/tready)
//   busy            high while accumulating
//   win_count       completed windows, wraps
module integrate_dump_ctrl #(
  parameter int DATA_IN_WIDTH  = 12,
  parameter int DATA_OUT_WIDTH = 28,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [CNT_WIDTH-1:0]             dec_len,
  input  logic signed [DATA_IN_WIDTH-1:0]  s_axis_tdata,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  output logic signed [DATA_OUT_WIDTH-1:0] m_axis_tdata,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             busy,
  output logic [CNT_WIDTH-1:0]             win_count
);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                      state, state_nxt;
  logic signed [DATA_OUT_WIDTH-1:0] acc, sample_ext, sum;
  logic [CNT_WIDTH-1:0]        cnt, n_lat, len_eff;
  logic                        last_slot, accept, load;

  assign len_eff    = (dec_len == '0) ? CNT_WIDTH'(1) : dec_len;
  assign sample_ext = DATA_OUT_WIDTH'(s_axis_tdata);
  assign sum        = acc + sample_ext;
  assign last_slot  = (cnt == n_lat - CNT_WIDTH'(1));
  assign accept     = s_axis_tvalid && s_axis_tready;
  assign load       = accept && last_slot;
  assign busy       = (state == ACCUM);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // The last sample of a window is held off only while the output
  // register is still occupied and not draining this cycle; every other
  // sample flows straight in.
  always_comb begin
    state_nxt     = state;
    s_axis_tready = 1'b0;
    case (state)
      IDLE:  if (enable) state_nxt = ACCUM;
      ACCUM: begin
        if (!enable) state_nxt = IDLE;
        else         s_axis_tready = !(last_slot && m_axis_tvalid && !m_axis_tready);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc           <= '0;
      cnt           <= '0;
      n_lat         <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      win_count     <= '0;
    end else begin
      // A fresh sum wins over a same-cycle consume, so tvalid stays up.
      if (load) begin
        m_axis_tdata  <= sum;
        m_axis_tvalid <= 1'b1;
        win_count     <= win_count + CNT_WIDTH'(1);
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end

      case (state)
        IDLE: if (enable) begin
          n_lat <= len_eff;
          acc   <= '0;
          cnt   <= '0;
        end
        ACCUM: begin
          if (!enable) begin
            acc <= '0;
            cnt <= '0;
          end else if (accept) begin
            if (last_slot) begin
              acc   <= '0;
              cnt   <= '0;
              n_lat <= len_eff;
            end else begin
              acc <= sum;
              cnt <= cnt + CNT_WIDTH'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_integrate_dump_ctrl.sv
module tb_integrate_dump_ctrl;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               enable = 1'b0;
  logic [15:0]        dec_len = '0;
  logic signed [11:0] s_tdata = '0;
  logic               s_tvalid = 1'b0;
  logic               s_tready;
  logic signed [27:0] m_tdata;
  logic               m_tvalid;
  logic               m_tready = 1'b1;
  logic               busy;
  logic [15:0]        win_count;

  // narrow-accumulator instance for the wrap case
  logic               en2 = 1'b0;
  logic [15:0]        dec2 = '0;
  logic signed [11:0] s2_data = '0;
  logic               s2_valid = 1'b0;
  logic               s2_ready;
  logic signed [12:0] m2_data;
  logic               m2_valid;
  logic               m2_ready = 1'b1;
  logic               busy2;
  logic [15:0]        win2;

  always #5 clk = ~clk;

  integrate_dump_ctrl #(.DATA_IN_WIDTH(12), .DATA_OUT_WIDTH(28), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .dec_len(dec_len),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .busy(busy), .win_count(win_count)
  );

  integrate_dump_ctrl #(.DATA_IN_WIDTH(12), .DATA_OUT_WIDTH(13), .CNT_WIDTH(16)) dut13 (
    .clk(clk), .reset(reset), .enable(en2), .dec_len(dec2),
    .s_axis_tdata(s2_data), .s_axis_tvalid(s2_valid), .s_axis_tready(s2_ready),
    .m_axis_tdata(m2_data), .m_axis_tvalid(m2_valid), .m_axis_tready(m2_ready),
    .busy(busy2), .win_count(win2)
  );

  int vectors = 0;
  int miscompares = 0;
  int sb[$];
  int mdl_acc, mdl_cnt, mdl_n, mdl_wins;

  // Scoreboard consumer: every output handshake pops one expected sum.
  task automatic monitor();
    int exp;
    forever begin
      @(negedge clk);
      if (!reset && m_tvalid && m_tready) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL out_unexpected got=%0d required=none", m_tdata);
        end else begin
          exp = sb.pop_front();
          if (m_tdata !== 28'(exp)) begin
            miscompares++;
            $display("FAIL out_sum got=%0d required=%0d", m_tdata, exp);
          end
        end
      end
    end
  endtask

  // Offer one sample and wait for it to be taken; the model tracks the window.
  task automatic send(input int x);
    int t = 0;
    s_tdata  = 12'(x);
    s_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_tready) break;
      t++;
      if (t > 50) break;
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    if (t > 50) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout got=no_accept required=accept sample=%0d", x);
    end else begin
      mdl_acc += x;
      if (mdl_cnt == mdl_n - 1) begin
        sb.push_back(mdl_acc);
        mdl_acc  = 0;
        mdl_cnt  = 0;
        mdl_n    = (dec_len == 0) ? 1 : int'(dec_len);
        mdl_wins++;
      end else begin
        mdl_cnt++;
      end
    end
  endtask

  task automatic start_win(input int len);
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    dec_len = 16'(len);
    mdl_n   = (len == 0) ? 1 : len;
    mdl_acc = 0;
    mdl_cnt = 0;
    enable  = 1'b1;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({s_tready, m_tvalid, busy} !== 3'b000 || m_tdata !== 28'd0 || win_count !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_state got=rdy%b vld%b busy%b d%0d wc%0d required=all_zero",
               s_tready, m_tvalid, busy, m_tdata, win_count);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    mdl_wins = 0;
  endtask

  task automatic test_basic();
    m_tready = 1'b1;
    start_win(4);
    for (int i = 1; i <= 4; i++) send(i);
    vectors++;
    if (m_tvalid !== 1'b1 || m_tdata !== 28'sd10) begin
      miscompares++;
      $display("FAIL basic_latency1 got=vld%b d%0d required=vld1 d10", m_tvalid, m_tdata);
    end
    for (int i = 5; i <= 8; i++) send(i);
    vectors++;
    if (m_tvalid !== 1'b1 || m_tdata !== 28'sd26) begin
      miscompares++;
      $display("FAIL basic_latency2 got=vld%b d%0d required=vld1 d26", m_tvalid, m_tdata);
    end
    drain();
    vectors++;
    if (win_count !== 16'(mdl_wins) || mdl_wins != 2) begin
      miscompares++;
      $display("FAIL basic_win_count got=%0d required=2", win_count);
    end
  endtask

  task automatic test_negative();
    int xs[3] = '{-5, -7, 2};
    start_win(3);
    foreach (xs[i]) begin
      send(xs[i]);
      vectors++;
      if (busy !== 1'b1) begin
        miscompares++;
        $display("FAIL neg_busy got=%b required=1", busy);
      end
    end
    vectors++;
    if (m_tdata !== 28'hFFFFFF6) begin
      miscompares++;
      $display("FAIL neg_sum got=%h required=ffffff6", m_tdata);
    end
    drain();
  endtask

  task automatic test_backpressure();
    m_tready = 1'b0;
    start_win(2);
    send(1); send(2); send(3);
    s_tdata  = 12'sd4;
    s_tvalid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (s_tready !== 1'b0 || m_tvalid !== 1'b1 || m_tdata !== 28'sd3) begin
        miscompares++;
        $display("FAIL bp_stall got=rdy%b vld%b d%0d required=rdy0 vld1 d3",
                 s_tready, m_tvalid, m_tdata);
      end
    end
    @(posedge clk); #1;
    m_tready = 1'b1;
    send(4); send(5); send(6);
    drain();
  endtask

  task automatic test_len_zero();
    int xs[4] = '{5, -3, 2047, -2048};
    start_win(0);
    foreach (xs[i]) send(xs[i]);
    drain();
  endtask

  task automatic test_enable_drop();
    start_win(8);
    for (int i = 0; i < 3; i++) send(100);
    enable = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || m_tvalid !== 1'b0 || s_tready !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_idle got=busy%b vld%b rdy%b required=0 0 0", busy, m_tvalid, s_tready);
    end
    start_win(8);
    for (int i = 0; i < 8; i++) send(1);
    drain();
  endtask

  task automatic test_mid_reset();
    m_tready = 1'b0;
    start_win(2);
    send(1); send(2); send(5);
    vectors++;
    if (m_tvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_pre got=vld%b required=1", m_tvalid);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({s_tready, m_tvalid, busy} !== 3'b000 || m_tdata !== 28'd0 || win_count !== 16'd0) begin
      miscompares++;
      $display("FAIL rst_mid got=rdy%b vld%b busy%b d%0d wc%0d required=all_zero",
               s_tready, m_tvalid, busy, m_tdata, win_count);
    end
    enable = 1'b0;
    sb.delete();
    mdl_wins = 0;
    @(posedge clk); #1;
    reset    = 1'b0;
    m_tready = 1'b1;
  endtask

  task automatic test_wrap();
    int k = 0;
    int t = 0;
    dec2     = 16'd4;
    en2      = 1'b1;
    s2_data  = 12'sd2047;
    s2_valid = 1'b1;
    while (k < 4 && t < 50) begin
      @(negedge clk);
      if (s2_ready) k++;
      t++;
    end
    @(posedge clk); #1;
    s2_valid = 1'b0;
    vectors++;
    if (k != 4 || m2_valid !== 1'b1 || m2_data !== -13'sd4) begin
      miscompares++;
      $display("FAIL wrap_sum got=vld%b d%0d accepts%0d required=vld1 d-4 accepts4", m2_valid, m2_data, k);
    end
    vectors++;
    if (win2 !== 16'd1) begin
      miscompares++;
      $display("FAIL wrap_win_count got=%0d required=1", win2);
    end
    en2 = 1'b0;
  endtask

  initial begin
    mdl_acc = 0; mdl_cnt = 0; mdl_n = 1; mdl_wins = 0;
    fork monitor(); join_none
    test_reset();
    test_basic();
    test_negative();
    test_backpressure();
    test_len_zero();
    test_enable_drop();
    test_mid_reset();
    test_wrap();
    start_win(1);
    send(-9);
    drain();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL leftover got=%0d required=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
